// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with the PC register, the imem request port and the IF/ID latch.
// It tolerates variable-latency imem, parks a word across a stall and drains a stale request after a redirect.
//
// state    | meaning
// ST_RUN   | request outstanding at r_pc; completion loads IF/ID or parks the word
// ST_HOLD  | word parked in r_buf while IF/ID is stalled; no request issued
// ST_DRAIN | stale request at r_pc still in flight; r_pend holds the redirect target
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall_IF,
  input  logic        i_flush_IF,
  input  logic        i_jal_ID,
  input  logic [31:0] i_jal_target_ID,
  input  logic        i_redirect_EX,
  input  logic [31:0] i_target_EX,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_ready,
  output logic [31:0] o_pc_IF,
  output logic [31:0] o_pc_ID,
  output logic [31:0] o_instr_ID,
  output logic        o_valid_ID
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_pend, w_pend_nxt;
  logic [31:0] r_buf, w_buf_nxt;
  logic [31:0] r_pc_id, w_pc_id_nxt;
  logic [31:0] r_instr_id, w_instr_id_nxt;
  logic        r_valid_id, w_valid_id_nxt;

  logic        w_redir;
  logic        w_squash;
  logic        w_bubble;
  logic [31:0] w_tgt_raw;
  logic [31:0] w_tgt;
  logic [31:0] w_pc_inc;

  // EX redirect is older than the ID JAL, so it wins
  assign w_redir   = i_redirect_EX | i_jal_ID;
  assign w_tgt_raw = i_redirect_EX ? i_target_EX : i_jal_target_ID;
  assign w_tgt     = w_tgt_raw & ~32'd3;
  assign w_squash  = w_redir | i_flush_IF;
  assign w_pc_inc  = r_pc + 32'd4;

  assign o_imem_addr = r_pc;
  assign o_pc_IF     = r_pc;
  assign o_pc_ID     = r_pc_id;
  assign o_instr_ID  = r_instr_id;
  assign o_valid_ID  = r_valid_id;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_nxt     = r_pend;
    w_buf_nxt      = r_buf;
    w_pc_id_nxt    = r_pc_id;
    w_instr_id_nxt = r_instr_id;
    w_valid_id_nxt = r_valid_id;
    w_bubble       = w_squash;
    o_imem_req     = 1'b0;

    case (r_state)
      ST_RUN: begin
        o_imem_req = 1'b1;
        if (w_redir) begin
          if (i_imem_ready) begin
            w_pc_nxt = w_tgt;
          end else begin
            w_pend_nxt  = w_tgt;
            w_state_nxt = ST_DRAIN;
          end
        end else if (!i_flush_IF) begin
          if (i_imem_ready && !i_stall_IF) begin
            w_pc_id_nxt    = r_pc;
            w_instr_id_nxt = i_imem_rdata;
            w_valid_id_nxt = 1'b1;
            w_pc_nxt       = w_pc_inc;
          end else if (i_imem_ready) begin
            w_buf_nxt   = i_imem_rdata;
            w_state_nxt = ST_HOLD;
          end else if (!i_stall_IF) begin
            w_bubble = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (w_redir) begin
          w_pc_nxt    = w_tgt;
          w_state_nxt = ST_RUN;
        end else if (i_flush_IF) begin
          // parked word is squashed; refetch the same PC
          w_state_nxt = ST_RUN;
        end else if (!i_stall_IF) begin
          w_pc_id_nxt    = r_pc;
          w_instr_id_nxt = r_buf;
          w_valid_id_nxt = 1'b1;
          w_pc_nxt       = w_pc_inc;
          w_state_nxt    = ST_RUN;
        end
      end
      ST_DRAIN: begin
        o_imem_req = 1'b1;
        w_bubble   = 1'b1;
        if (i_imem_ready) begin
          w_pc_nxt    = w_redir ? w_tgt : r_pend;
          w_state_nxt = ST_RUN;
        end else if (w_redir) begin
          w_pend_nxt = w_tgt;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    if (w_bubble) begin
      w_pc_id_nxt    = 32'd0;
      w_instr_id_nxt = NOP_INSTR;
      w_valid_id_nxt = 1'b0;
    end

    if (i_rst) begin
      o_imem_req = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_pend     <= 32'd0;
      r_buf      <= 32'd0;
      r_pc_id    <= 32'd0;
      r_instr_id <= NOP_INSTR;
      r_valid_id <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend     <= w_pend_nxt;
      r_buf      <= w_buf_nxt;
      r_pc_id    <= w_pc_id_nxt;
      r_instr_id <= w_instr_id_nxt;
      r_valid_id <= w_valid_id_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios followed by random hazards and imem latency,
// every cycle compared against a behavioural fetch model.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_stall_IF = 1'b0;
  logic        i_flush_IF = 1'b0;
  logic        i_jal_ID = 1'b0;
  logic [31:0] i_jal_target_ID = 32'd0;
  logic        i_redirect_EX = 1'b0;
  logic [31:0] i_target_EX = 32'd0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_rdata = 32'd0;
  logic        i_imem_ready = 1'b0;
  logic [31:0] o_pc_IF;
  logic [31:0] o_pc_ID;
  logic [31:0] o_instr_ID;
  logic        o_valid_ID;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_stall_IF(i_stall_IF), .i_flush_IF(i_flush_IF),
    .i_jal_ID(i_jal_ID), .i_jal_target_ID(i_jal_target_ID),
    .i_redirect_EX(i_redirect_EX), .i_target_EX(i_target_EX),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_rdata(i_imem_rdata), .i_imem_ready(i_imem_ready),
    .o_pc_IF(o_pc_IF), .o_pc_ID(o_pc_ID), .o_instr_ID(o_instr_ID), .o_valid_ID(o_valid_ID)
  );

  int n_chk = 0;
  int n_pass = 0;

  // reference model: fetch address, a parked word, a pending redirect for a stale request
  logic [31:0] m_pc, m_pend, m_buf, m_pc_id, m_instr_id;
  logic        m_valid_id;
  logic        m_parked = 1'b0;
  logic        m_stale = 1'b0;
  logic        m_known = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic m_bubble();
    m_pc_id = 32'd0;
    m_instr_id = NOP;
    m_valid_id = 1'b0;
  endtask

  task automatic m_issue(input logic [31:0] pc, input logic [31:0] w);
    m_pc_id = pc;
    m_instr_id = w;
    m_valid_id = 1'b1;
  endtask

  task automatic model_update(input logic rst, input logic st, input logic fl,
                              input logic jl, input logic [31:0] jt,
                              input logic rx, input logic [31:0] rt, input logic rdy);
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] word;
    redir = rx | jl;
    tgt   = (rx ? rt : jt) & 32'hFFFF_FFFC;
    word  = mem_word(m_pc);
    if (rst) begin
      m_pc = RST_PC; m_parked = 1'b0; m_stale = 1'b0; m_known = 1'b1;
      m_bubble();
    end else if (m_stale) begin
      m_bubble();
      if (rdy) begin
        m_pc = redir ? tgt : m_pend;
        m_stale = 1'b0;
      end else if (redir) begin
        m_pend = tgt;
      end
    end else if (m_parked) begin
      if (redir || fl) begin
        m_bubble();
        if (redir) m_pc = tgt;
        m_parked = 1'b0;
      end else if (!st) begin
        m_issue(m_pc, m_buf);
        m_pc = m_pc + 32'd4;
        m_parked = 1'b0;
      end
    end else begin
      if (redir) begin
        m_bubble();
        if (rdy) m_pc = tgt;
        else begin m_pend = tgt; m_stale = 1'b1; end
      end else if (fl) begin
        m_bubble();
      end else if (rdy && !st) begin
        m_issue(m_pc, word);
        m_pc = m_pc + 32'd4;
      end else if (rdy) begin
        m_buf = word;
        m_parked = 1'b1;
      end else if (!st) begin
        m_bubble();
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic st, input logic fl,
                     input logic jl, input logic [31:0] jt,
                     input logic rx, input logic [31:0] rt, input logic rdy);
    @(negedge clk);
    i_rst = rst; i_stall_IF = st; i_flush_IF = fl;
    i_jal_ID = jl; i_jal_target_ID = jt;
    i_redirect_EX = rx; i_target_EX = rt;
    i_imem_ready = rdy;
    i_imem_rdata = rdy ? mem_word(m_pc) : $urandom;
    #1;
    chk("imem_req", {31'd0, o_imem_req}, {31'd0, !rst && m_known && !m_parked});
    if (m_known) begin
      if (!rst && !m_parked) chk("imem_addr", o_imem_addr, m_pc);
      chk("pc_IF", o_pc_IF, m_pc);
      chk("pc_ID", o_pc_ID, m_pc_id);
      chk("instr_ID", o_instr_ID, m_instr_id);
      chk("valid_ID", {31'd0, o_valid_ID}, {31'd0, m_valid_id});
    end
    model_update(rst, st, fl, jl, jt, rx, rt, rdy);
  endtask

  task automatic run(input logic rdy);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, rdy);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // T1: reset then zero-wait streaming
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    after_edge();
    chk("t1_reset_pc_IF", o_pc_IF, RST_PC);
    chk("t1_reset_valid", {31'd0, o_valid_ID}, 32'd0);
    chk("t1_reset_instr", o_instr_ID, NOP);
    run(1'b1);
    after_edge();
    chk("t1_first_pc_ID", o_pc_ID, 32'h0);
    chk("t1_first_valid", {31'd0, o_valid_ID}, 32'd1);
    run(1'b1);
    run(1'b1);
    after_edge();
    chk("t1_third_pc_ID", o_pc_ID, 32'h8);
    run(1'b1);

    // T2: stall two cycles with 0x10 in flight
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    after_edge();
    chk("t2_hold_pc_ID", o_pc_ID, 32'hC);
    chk("t2_hold_req", {31'd0, o_imem_req}, 32'd0);
    run(1'b1);
    after_edge();
    chk("t2_release_pc_ID", o_pc_ID, 32'h10);
    chk("t2_release_instr", o_instr_ID, mem_word(32'h10));
    run(1'b1);
    after_edge();
    chk("t2_next_pc_ID", o_pc_ID, 32'h14);

    // T3: EX and ID redirect together, EX wins
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1);
    after_edge();
    chk("t3_pc_IF", o_pc_IF, 32'h200);
    chk("t3_bubble", {31'd0, o_valid_ID}, 32'd0);
    run(1'b1);
    after_edge();
    chk("t3_pc_ID", o_pc_ID, 32'h200);

    // T4: JAL during a 3-cycle access
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0, 1'b0);
    after_edge();
    chk("t4_addr_held_1", o_imem_addr, 32'h204);
    run(1'b0);
    after_edge();
    chk("t4_addr_held_2", o_imem_addr, 32'h204);
    run(1'b1);
    after_edge();
    chk("t4_pc_IF", o_pc_IF, 32'h40);
    chk("t4_dropped", {31'd0, o_valid_ID}, 32'd0);
    run(1'b1);
    after_edge();
    chk("t4_pc_ID", o_pc_ID, 32'h40);

    // T5: redirect while holding a parked word at 0x20
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h80, 1'b0);
    after_edge();
    chk("t5_pc_IF", o_pc_IF, 32'h80);
    chk("t5_discard", {31'd0, o_valid_ID}, 32'd0);
    run(1'b1);
    after_edge();
    chk("t5_pc_ID", o_pc_ID, 32'h80);
    chk("t5_instr", o_instr_ID, mem_word(32'h80));

    // T6: reset in the middle of a wait
    run(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    chk("t6_req_in_reset", {31'd0, o_imem_req}, 32'd0);
    after_edge();
    chk("t6_pc_IF", o_pc_IF, RST_PC);
    run(1'b0);
    after_edge();
    chk("t6_wait_valid", {31'd0, o_valid_ID}, 32'd0);
    run(1'b1);
    after_edge();
    chk("t6_first_pc_ID", o_pc_ID, RST_PC);
    chk("t6_first_valid", {31'd0, o_valid_ID}, 32'd1);

    // random hazards, redirects (misaligned targets included) and imem latency
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(99) < 1,
          $urandom_range(99) < 20,
          $urandom_range(99) < 8,
          $urandom_range(99) < 8, $urandom,
          $urandom_range(99) < 8, $urandom,
          $urandom_range(99) < 60);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
